// File: rtl/led_pwm_controller.sv
// Memory-mapped N-channel LED controller: off / on / PWM-dimmed / blinking per channel.
// Latency: led_port is registered, one cycle behind counter and register state; reads are combinational.
// Backpressure: none; every write strobe is accepted on the clock edge it is sampled.
module led_pwm_controller #(
  parameter int N_LEDS = 8,
  parameter int DUTY_W = 8,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic [N_LEDS-1:0] led_port
);

  localparam logic [ADDR_W-1:0] A_CTRL  = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_PRESC = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_BCAST = ADDR_W'(2);

  localparam logic [1:0] M_OFF   = 2'b00;
  localparam logic [1:0] M_ON    = 2'b01;
  localparam logic [1:0] M_PWM   = 2'b10;
  localparam logic [1:0] M_BLINK = 2'b11;

  // Register file
  logic                           r_en;
  logic                           r_inv;
  logic [DATA_W-1:0]              r_presc;
  logic [N_LEDS-1:0][DUTY_W-1:0]  r_duty;
  logic [N_LEDS-1:0][1:0]         r_mode;

  // Shared timebase
  logic [DATA_W-1:0] r_pc;
  logic [DUTY_W-1:0] r_cnt;
  logic              r_bp;
  logic [N_LEDS-1:0] r_led;

  logic              w_wr_presc;
  logic              w_tick;
  logic              w_wrap;
  logic [N_LEDS-1:0] w_lit;
  logic [DATA_W-1:0] w_rd_dat;

  assign w_wr_presc = wr_en && (addr == A_PRESC);
  assign w_tick     = r_en && (r_pc == r_presc);
  assign w_wrap     = w_tick && (r_cnt == {DUTY_W{1'b1}});

  // Register writes; a broadcast loads every duty register at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_en    <= 1'b0;
      r_inv   <= 1'b0;
      r_presc <= '0;
      r_duty  <= '0;
      r_mode  <= '0;
    end else if (wr_en) begin
      if (addr == A_CTRL) begin
        r_en  <= data_in[0];
        r_inv <= data_in[1];
      end
      if (addr == A_PRESC) r_presc <= data_in;
      for (int i = 0; i < N_LEDS; i++) begin
        if (addr == A_BCAST || addr == ADDR_W'(4 + 2 * i)) r_duty[i] <= data_in[DUTY_W-1:0];
        if (addr == ADDR_W'(5 + 2 * i)) r_mode[i] <= data_in[1:0];
      end
    end
  end

  // Prescaler, PWM counter and blink phase; all parked at zero while disabled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc  <= '0;
      r_cnt <= '0;
      r_bp  <= 1'b0;
    end else if (!r_en) begin
      r_pc  <= '0;
      r_cnt <= '0;
      r_bp  <= 1'b0;
    end else begin
      // A prescaler rewrite restarts the tick interval from the write edge
      if (w_wr_presc || w_tick) r_pc <= '0;
      else                      r_pc <= r_pc + DATA_W'(1);
      if (w_tick) r_cnt <= r_cnt + DUTY_W'(1);
      if (w_wrap) r_bp  <= ~r_bp;
    end
  end

  // Per-channel lit decision from mode, duty compare and blink phase
  always_comb begin
    w_lit = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      case (r_mode[i])
        M_OFF:   w_lit[i] = 1'b0;
        M_ON:    w_lit[i] = 1'b1;
        M_PWM:   w_lit[i] = (r_cnt < r_duty[i]);
        M_BLINK: w_lit[i] = r_bp && (r_cnt < r_duty[i]);
        default: w_lit[i] = 1'b0;
      endcase
    end
  end

  // Registered pin drive; disabled channels sit at the dark level for the chosen polarity
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      r_led <= '0;
    else if (!r_en) r_led <= {N_LEDS{r_inv}};
    else            r_led <= w_lit ^ {N_LEDS{r_inv}};
  end

  // Combinational readback; a same-cycle write shows the pre-write value
  always_comb begin
    w_rd_dat = '0;
    if (rd_en) begin
      if (addr == A_CTRL)  w_rd_dat = DATA_W'({r_inv, r_en});
      if (addr == A_PRESC) w_rd_dat = r_presc;
      for (int i = 0; i < N_LEDS; i++) begin
        if (addr == ADDR_W'(4 + 2 * i)) w_rd_dat = DATA_W'(r_duty[i]);
        if (addr == ADDR_W'(5 + 2 * i)) w_rd_dat = DATA_W'(r_mode[i]);
      end
    end
  end

  assign data_out = w_rd_dat;
  assign led_port = r_led;

endmodule

// File: tb/tb_led_pwm_controller.sv
// Directed bench for led_pwm_controller: register map, static modes, PWM duty, prescaler, blink, reset.
// Inputs are driven on the falling edge; outputs are sampled on the falling edge or 1ns after a change.
// Each comparison is an immediate assertion that counts and reports any failure.
module tb_led_pwm_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [4:0] addr = '0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic [7:0] led_port;

  int n_checks = 0;
  int n_fail   = 0;
  int hi_a;
  int hi_b;

  led_pwm_controller #(.N_LEDS(8), .DUTY_W(8), .DATA_W(8), .ADDR_W(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .led_port (led_port)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; addr = a; data_in = d;
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [7:0] exp, input string tag);
    rd_en = 1'b1; addr = a;
    #1 check(tag, {24'd0, data_out}, {24'd0, exp});
    rd_en = 1'b0;
  endtask

  // Count high samples of one LED bit over n consecutive cycles
  task automatic count_hi(input int bit_i, input int n, output int hi);
    hi = 0;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      if (led_port[bit_i]) hi++;
    end
  endtask

  initial begin
    // Reset state and readback
    #12;
    check("reset_led", {24'd0, led_port}, 32'd0);
    rd(5'd0, 8'h00, "reset_rd_ctrl_in_reset");
    @(negedge clk) reset = 1'b0;
    for (int a = 0; a < 20; a++) rd(5'(a), 8'h00, $sformatf("rd_after_reset_a%0d", a));
    wr(5'd10, 8'hA5);
    rd(5'd10, 8'hA5, "duty3_readback");
    rd(5'd31, 8'h00, "addr31_reads_0");
    wr(5'd0, 8'hFF);
    rd(5'd0, 8'h03, "ctrl_upper_bits_0");
    wr(5'd0, 8'h00);
    wr(5'd15, 8'hFF);
    rd(5'd15, 8'h03, "mode_upper_bits_0");
    wr(5'd15, 8'h00);
    wr(5'd2, 8'h5A);
    rd(5'd2, 8'h00, "bcast_reads_0");
    rd(5'd4, 8'h5A, "bcast_duty0");
    rd(5'd10, 8'h5A, "bcast_duty3");
    wr(5'd3, 8'h77);
    rd(5'd3, 8'h00, "reserved_reads_0");

    // Same-cycle read and write of one address shows the old value
    wr(5'd1, 8'h09);
    @(negedge clk);
    wr_en = 1'b1; rd_en = 1'b1; addr = 5'd1; data_in = 8'h07;
    #1 check("rd_during_wr_old", {24'd0, data_out}, 32'h09);
    @(posedge clk);
    #1 begin wr_en = 1'b0; rd_en = 1'b0; end
    rd(5'd1, 8'h07, "rd_after_wr_new");

    // Static on/off with and without inversion
    wr(5'd5, 8'h01);
    wr(5'd7, 8'h00);
    wr(5'd0, 8'h01);
    @(negedge clk);
    check("static_led0_latency", {31'd0, led_port[0]}, 32'd0);
    @(negedge clk);
    check("static_led0_on", {31'd0, led_port[0]}, 32'd1);
    check("static_led1_off", {31'd0, led_port[1]}, 32'd0);
    wr(5'd0, 8'h03);
    @(negedge clk);
    @(negedge clk);
    check("inv_led0", {31'd0, led_port[0]}, 32'd0);
    check("inv_led1", {31'd0, led_port[1]}, 32'd1);

    // PWM duty over a full period with a tick every cycle
    wr(5'd0, 8'h00);
    wr(5'd5, 8'h00);
    wr(5'd1, 8'h00);
    wr(5'd8, 8'd64);
    wr(5'd9, 8'h02);
    wr(5'd0, 8'h01);
    repeat (3) @(negedge clk);
    count_hi(2, 256, hi_a);
    check("pwm_duty64", hi_a, 32'd64);
    wr(5'd8, 8'd0);
    repeat (2) @(negedge clk);
    count_hi(2, 256, hi_a);
    check("pwm_duty0", hi_a, 32'd0);
    wr(5'd8, 8'd255);
    repeat (2) @(negedge clk);
    count_hi(2, 256, hi_a);
    check("pwm_duty255", hi_a, 32'd255);

    // Prescaler 3: cnt stays at 0 for four cycles after enable
    wr(5'd8, 8'd1);
    wr(5'd0, 8'h00);
    wr(5'd1, 8'h03);
    wr(5'd0, 8'h01);
    @(negedge clk);
    check("presc_first_cycle", {31'd0, led_port[2]}, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("presc_cnt0_k%0d", k), {31'd0, led_port[2]}, 32'd1);
    end
    @(negedge clk);
    check("presc_cnt1", {31'd0, led_port[2]}, 32'd0);

    // Prescaler rewrite mid-count restarts the interval
    wr(5'd0, 8'h00);
    wr(5'd0, 8'h01);
    @(posedge clk);
    wr(5'd1, 8'h03);
    @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("presc_restart_k%0d", k), {31'd0, led_port[2]}, 32'd1);
    end
    @(negedge clk);
    check("presc_restart_tick", {31'd0, led_port[2]}, 32'd0);

    // Blink with broadcast duty: dark half-period, then 255 of 256 lit
    wr(5'd0, 8'h00);
    wr(5'd1, 8'h00);
    wr(5'd2, 8'hFF);
    wr(5'd15, 8'h03);
    wr(5'd0, 8'h01);
    @(negedge clk);
    count_hi(5, 256, hi_a);
    count_hi(5, 256, hi_b);
    check("blink_first_half", hi_a, 32'd0);
    check("blink_second_half", hi_b, 32'd255);

    // Asynchronous reset mid-operation
    wr(5'd5, 8'h01);
    repeat (2) @(negedge clk);
    check("pre_reset_led_nonzero", {31'd0, (led_port != 8'h00)}, 32'd1);
    rd_en = 1'b1; addr = 5'd10;
    reset = 1'b1;
    #1 check("async_reset_led", {24'd0, led_port}, 32'd0);
    check("async_reset_rd", {24'd0, data_out}, 32'd0);
    rd_en = 1'b0;
    @(negedge clk) reset = 1'b0;
    for (int a = 0; a < 20; a++) rd(5'(a), 8'h00, $sformatf("rd_after_midreset_a%0d", a));
    repeat (3) @(negedge clk);
    check("led_after_midreset", {24'd0, led_port}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
